// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the memory access unit: EXE op codes, bus size
// encodings, FSM states and small op-decoding helpers.
package mem_access_unit_pkg;

    // Memory op codes from the datapath's EXE_*_OP set
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    // Bus transfer size encodings
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Access FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic is_load_op(input logic [7:0] code);
        return (code == EXE_LB_OP)  || (code == EXE_LBU_OP) ||
               (code == EXE_LH_OP)  || (code == EXE_LHU_OP) ||
               (code == EXE_LW_OP);
    endfunction

    function automatic logic is_store_op(input logic [7:0] code);
        return (code == EXE_SB_OP) || (code == EXE_SH_OP) || (code == EXE_SW_OP);
    endfunction

    function automatic logic is_mem_op(input logic [7:0] code);
        return is_load_op(code) || is_store_op(code);
    endfunction

    // Transfer size implied by a memory op; non-memory ops fall to word
    function automatic logic [1:0] op_size(input logic [7:0] code);
        logic [1:0] sz;
        case (code)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: sz = SIZE_BYTE;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: sz = SIZE_HALF;
            default:                          sz = SIZE_WORD;
        endcase
        return sz;
    endfunction

    // Natural alignment: halves on even addresses, words on multiples of 4
    function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] lo);
        logic ok;
        case (sz)
            SIZE_HALF: ok = ~lo[0];
            SIZE_WORD: ok = (lo == 2'b00);
            default:   ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// Combinational load-result formatter: selects the addressed byte or half
// from the returned bus word and sign- or zero-extends it.
module mem_access_unit_load_formatter (
    input  logic [7:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data_rdata,
    output logic [31:0] rdata
);
    import mem_access_unit_pkg::*;

    logic [7:0]  lane [4];
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Split the bus word into its four byte lanes
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = data_rdata[8*gi +: 8];
    end

    // Pick the addressed lane(s) and extend according to the op
    always_comb begin
        byte_v = lane[addr_lo];
        half_v = addr_lo[1] ? data_rdata[31:16] : data_rdata[15:0];
        case (op)
            EXE_LB_OP:  rdata = {{24{byte_v[7]}}, byte_v};
            EXE_LBU_OP: rdata = {24'h000000, byte_v};
            EXE_LH_OP:  rdata = {{16{half_v[15]}}, half_v};
            EXE_LHU_OP: rdata = {16'h0000, half_v};
            default:    rdata = data_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: alignment check, store lane replication,
// single-outstanding request/response bus handshake and pipeline stall.
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [7:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic              result_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              adel,
    output logic              ades,
    output logic [ADDR_W-1:0] badvaddr,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);
    import mem_access_unit_pkg::*;

    state_e            state_q, state_d;
    logic [7:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              in_mem;
    logic              in_load;
    logic [1:0]        in_size;
    logic              in_aligned;
    logic              try_access;
    logic              accept;
    logic              misalign;
    logic [DATA_W-1:0] store_data;
    logic [DATA_W-1:0] fmt_rdata;

    // Decode the incoming op; only an IDLE unit looks at it
    always_comb begin
        in_mem     = is_mem_op(op);
        in_load    = is_load_op(op);
        in_size    = op_size(op);
        in_aligned = is_aligned(in_size, addr[1:0]);
        try_access = (state_q == ST_IDLE) && op_valid && in_mem;
        accept     = try_access && in_aligned;
        misalign   = try_access && !in_aligned;
        case (in_size)
            SIZE_BYTE: store_data = {4{wdata[7:0]}};
            SIZE_HALF: store_data = {2{wdata[15:0]}};
            default:   store_data = wdata;
        endcase
    end

    // Address errors are raised in the same cycle and never reach the bus
    always_comb begin
        adel     = misalign && in_load;
        ades     = misalign && !in_load;
        badvaddr = misalign ? addr : '0;
    end

    // Byte/half extraction of the returned bus word for the latched load
    mem_access_unit_load_formatter u_load_formatter (
        .op         (op_q),
        .addr_lo    (addr_q[1:0]),
        .data_rdata (data_rdata),
        .rdata      (fmt_rdata)
    );

    // Next-state and handshake outputs; reset suppresses requests at once
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        wr_d         = wr_q;
        rdata_d      = rdata_q;
        data_req     = 1'b0;
        result_valid = 1'b0;
        stall        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_REQ;
                    op_d    = op;
                    addr_d  = addr;
                    wdata_d = store_data;
                    size_d  = in_size;
                    wr_d    = !in_load;
                    stall   = 1'b1;
                end
            end
            ST_REQ: begin
                data_req = 1'b1;
                stall    = 1'b1;
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        state_d = ST_DONE;
                        if (!wr_q) begin
                            rdata_d = fmt_rdata;
                        end
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                if (data_data_ok) begin
                    state_d = ST_DONE;
                    if (!wr_q) begin
                        rdata_d = fmt_rdata;
                    end
                end
            end
            ST_DONE: begin
                result_valid = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (rst) begin
            data_req     = 1'b0;
            result_valid = 1'b0;
            stall        = 1'b0;
        end
    end

    // State and latched-request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end

    // Bus fields come straight from the latched request so they stay stable
    always_comb begin
        data_wr    = wr_q;
        data_size  = size_q;
        data_addr  = addr_q;
        data_wdata = wdata_q;
        rdata      = rdata_q;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed table, reset corner
// sequences and randomized transactions against a byte-level reference model.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        result_valid;
    logic [31:0] rdata;
    logic        adel;
    logic        ades;
    logic [31:0] badvaddr;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int n_vec = 0;
    int n_err = 0;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .op_valid     (op_valid),
        .op           (op),
        .addr         (addr),
        .wdata        (wdata),
        .stall        (stall),
        .result_valid (result_valid),
        .rdata        (rdata),
        .adel         (adel),
        .ades         (ades),
        .badvaddr     (badvaddr),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        adel;
        logic        ades;
        logic [31:0] badv;
        int          stall;
        int          req;
        int          rv;
        logic [31:0] rdata;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] baddr;
        bit          unstable;
        bit          timeout;
    } res_t;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] bus_rd;
        int          aok;
        int          dok;
        logic        adel;
        logic        ades;
        logic [31:0] badv;
        int          stall;
        int          req;
        logic [31:0] rdata;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] bus_wdata;
        bit          chk_wdata;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: works from access width in bytes and lane arithmetic
    function automatic res_t ref_model(input logic [7:0] o, input logic [31:0] a,
                                       input logic [31:0] w, input logic [31:0] rd,
                                       input int aok, input int dok,
                                       input logic [31:0] prev);
        res_t e;
        int nbytes;
        bit load;
        bit mem;
        int k;
        logic [31:0] b;
        logic [31:0] h;
        e = '{adel: 0, ades: 0, badv: 0, stall: 0, req: 0, rv: 0, rdata: prev,
              wr: 0, size: 0, wdata: 0, baddr: 0, unstable: 0, timeout: 0};
        mem = 1; load = 1; nbytes = 4;
        case (o)
            EXE_LB_OP, EXE_LBU_OP: nbytes = 1;
            EXE_LH_OP, EXE_LHU_OP: nbytes = 2;
            EXE_LW_OP:             nbytes = 4;
            EXE_SB_OP: begin nbytes = 1; load = 0; end
            EXE_SH_OP: begin nbytes = 2; load = 0; end
            EXE_SW_OP: begin nbytes = 4; load = 0; end
            default:   mem = 0;
        endcase
        if (!mem) return e;
        if ((a % nbytes) != 0) begin
            e.adel = load;
            e.ades = !load;
            e.badv = a;
            return e;
        end
        e.stall = 2 + aok + dok;
        e.req   = aok + 1;
        e.rv    = 1;
        e.wr    = !load;
        e.baddr = a;
        e.size  = (nbytes == 1) ? 2'd0 : (nbytes == 2) ? 2'd1 : 2'd2;
        e.wdata = (nbytes == 1) ? w[7:0] * 32'h0101_0101 :
                  (nbytes == 2) ? w[15:0] * 32'h0001_0001 : w;
        if (load) begin
            k = a % 4;
            b = (rd >> (8 * k)) & 32'hFF;
            h = (rd >> (8 * k)) & 32'hFFFF;
            case (o)
                EXE_LB_OP:  e.rdata = (b >= 128) ? (32'hFFFF_FF00 | b) : b;
                EXE_LBU_OP: e.rdata = b;
                EXE_LH_OP:  e.rdata = (h >= 32768) ? (32'hFFFF_0000 | h) : h;
                EXE_LHU_OP: e.rdata = h;
                default:    e.rdata = rd;
            endcase
        end
        return e;
    endfunction

    // Present one op and act as the bus slave with the given delays
    task automatic run_txn(input logic [7:0] op_i, input logic [31:0] a, input logic [31:0] w,
                           input logic [31:0] rd, input int aok_d, input int dok_d,
                           input bit spur, output res_t r);
        int reqcnt;
        int aok_cyc;
        int tail;
        bit fin;
        r = '{adel: 0, ades: 0, badv: 0, stall: 0, req: 0, rv: 0, rdata: 0,
              wr: 0, size: 0, wdata: 0, baddr: 0, unstable: 0, timeout: 0};
        reqcnt = 0; aok_cyc = -1; tail = -1; fin = 0;
        for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
            @(negedge clk);
            data_addr_ok = 0;
            data_data_ok = 0;
            data_rdata   = $urandom();
            if (cyc == 0) begin
                op_valid = 1; op = op_i; addr = a; wdata = w;
                if (spur) data_data_ok = 1;
            end
            if (cyc == tail) op_valid = 0;
            #1;
            if (data_req) begin
                if (reqcnt == 0) begin
                    r.wr = data_wr; r.size = data_size; r.wdata = data_wdata; r.baddr = data_addr;
                end else if (r.wr !== data_wr || r.size !== data_size ||
                             r.wdata !== data_wdata || r.baddr !== data_addr) begin
                    r.unstable = 1;
                end
                reqcnt++;
                if (reqcnt == aok_d + 1) begin
                    data_addr_ok = 1;
                    aok_cyc = cyc;
                end else if (spur) begin
                    data_data_ok = 1;
                end
            end
            if (aok_cyc >= 0 && cyc == aok_cyc + dok_d) begin
                data_data_ok = 1;
                data_rdata   = rd;
            end
            #1;
            if (cyc == 0) begin
                r.adel = adel; r.ades = ades; r.badv = badvaddr;
            end
            if (stall) r.stall++;
            if (data_req) r.req++;
            if (result_valid) r.rv++;
            if (tail < 0 && ((cyc == 0 && !stall) || result_valid)) tail = cyc + 1;
            if (cyc == tail) begin
                fin = 1;
                r.rdata = rdata;
            end
        end
        data_addr_ok = 0;
        data_data_ok = 0;
        op_valid     = 0;
        r.timeout    = !fin;
    endtask

    task automatic compare(input string tag, input res_t act, input res_t e);
        chk({tag, " timeout"}, 32'(act.timeout), 32'd0);
        chk({tag, " adel"}, 32'(act.adel), 32'(e.adel));
        chk({tag, " ades"}, 32'(act.ades), 32'(e.ades));
        chk({tag, " badvaddr"}, act.badv, e.badv);
        chk({tag, " stall_cycles"}, act.stall, e.stall);
        chk({tag, " req_cycles"}, act.req, e.req);
        chk({tag, " result_valid_pulses"}, act.rv, e.rv);
        chk({tag, " rdata"}, act.rdata, e.rdata);
        if (e.req > 0) begin
            chk({tag, " data_addr"}, act.baddr, e.baddr);
            chk({tag, " data_wr"}, 32'(act.wr), 32'(e.wr));
            chk({tag, " data_size"}, 32'(act.size), 32'(e.size));
            chk({tag, " bus_stable"}, 32'(act.unstable), 32'd0);
            if (e.wr) chk({tag, " data_wdata"}, act.wdata, e.wdata);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " stall"}, 32'(stall), 32'd0);
        chk({tag, " result_valid"}, 32'(result_valid), 32'd0);
        chk({tag, " data_req"}, 32'(data_req), 32'd0);
        chk({tag, " data_wr"}, 32'(data_wr), 32'd0);
        chk({tag, " data_size"}, 32'(data_size), 32'd0);
        chk({tag, " data_addr"}, data_addr, 32'd0);
        chk({tag, " data_wdata"}, data_wdata, 32'd0);
        chk({tag, " rdata"}, rdata, 32'd0);
        chk({tag, " adel"}, 32'(adel), 32'd0);
        chk({tag, " ades"}, 32'(ades), 32'd0);
        chk({tag, " badvaddr"}, badvaddr, 32'd0);
    endtask

    vec_t tbl[11];

    initial begin
        res_t r;
        res_t e;
        logic [31:0] last_rdata;
        logic [7:0] ops [10];
        rst = 1; op_valid = 0; op = 0; addr = 0; wdata = 0;
        data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;

        tbl[0]  = '{EXE_LB_OP,  32'h1003, 32'h0,         32'h80FF_0000, 0, 0, 0, 0, 32'h0,    2, 1, 32'hFFFF_FF80, 0, 2'd0, 32'h0,         0};
        tbl[1]  = '{EXE_LBU_OP, 32'h1003, 32'h0,         32'h80FF_0000, 0, 0, 0, 0, 32'h0,    2, 1, 32'h0000_0080, 0, 2'd0, 32'h0,         0};
        tbl[2]  = '{EXE_SH_OP,  32'h2002, 32'h1234_ABCD, 32'h0,         0, 0, 0, 0, 32'h0,    2, 1, 32'h0000_0080, 1, 2'd1, 32'hABCD_ABCD, 1};
        tbl[3]  = '{EXE_LW_OP,  32'h3002, 32'h0,         32'h0,         0, 0, 1, 0, 32'h3002, 0, 0, 32'h0000_0080, 0, 2'd0, 32'h0,         0};
        tbl[4]  = '{EXE_SW_OP,  32'h3001, 32'h55,        32'h0,         0, 0, 0, 1, 32'h3001, 0, 0, 32'h0000_0080, 0, 2'd0, 32'h0,         0};
        tbl[5]  = '{EXE_LW_OP,  32'h4000, 32'h0,         32'hDEAD_BEEF, 3, 2, 0, 0, 32'h0,    7, 4, 32'hDEAD_BEEF, 0, 2'd2, 32'h0,         0};
        tbl[6]  = '{EXE_LH_OP,  32'h0006, 32'h0,         32'h8001_7FFF, 1, 0, 0, 0, 32'h0,    3, 2, 32'hFFFF_8001, 0, 2'd1, 32'h0,         0};
        tbl[7]  = '{EXE_LHU_OP, 32'h0006, 32'h0,         32'h8001_7FFF, 0, 1, 0, 0, 32'h0,    3, 1, 32'h0000_8001, 0, 2'd1, 32'h0,         0};
        tbl[8]  = '{8'h25,      32'h3003, 32'h0,         32'h0,         0, 0, 0, 0, 32'h0,    0, 0, 32'h0000_8001, 0, 2'd0, 32'h0,         0};
        tbl[9]  = '{EXE_SB_OP,  32'h0001, 32'h0000_00A5, 32'h0,         2, 0, 0, 0, 32'h0,    4, 3, 32'h0000_8001, 1, 2'd0, 32'hA5A5_A5A5, 1};
        tbl[10] = '{EXE_LB_OP,  32'h0000, 32'h0,         32'h0000_007F, 0, 0, 0, 0, 32'h0,    2, 1, 32'h0000_007F, 0, 2'd0, 32'h0,         0};

        // Reset state, while reset is held and just after release
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk_idle_outputs("reset_held");
        @(negedge clk); rst = 0; #1;
        chk_idle_outputs("reset_released");

        // Directed table
        for (int i = 0; i < 11; i++) begin
            run_txn(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].bus_rd, tbl[i].aok, tbl[i].dok, 0, r);
            e = '{adel: tbl[i].adel, ades: tbl[i].ades, badv: tbl[i].badv,
                  stall: tbl[i].stall, req: tbl[i].req, rv: (tbl[i].req > 0) ? 1 : 0,
                  rdata: tbl[i].rdata, wr: tbl[i].wr, size: tbl[i].size,
                  wdata: tbl[i].bus_wdata, baddr: tbl[i].addr, unstable: 0, timeout: 0};
            if (!tbl[i].chk_wdata) e.wdata = r.wdata;
            $display("table %0d op=%h addr=%h stall=%0d req=%0d rv=%0d rdata=%h",
                     i, tbl[i].op, tbl[i].addr, r.stall, r.req, r.rv, r.rdata);
            compare($sformatf("table%0d", i), r, e);
        end

        // Reset while waiting for data; a late data_ok must be discarded
        @(negedge clk); op_valid = 1; op = EXE_LW_OP; addr = 32'h5000;
        @(negedge clk); #1; data_addr_ok = 1;
        @(negedge clk); data_addr_ok = 0; #1;
        chk("rst_wait pre stall", 32'(stall), 32'd1);
        rst = 1; #1;
        chk("rst_wait data_req", 32'(data_req), 32'd0);
        @(negedge clk); rst = 0; op_valid = 0; #1;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin data_data_ok = 1; data_rdata = 32'hCAFE_BABE; end
            #1;
            chk_idle_outputs($sformatf("rst_wait c%0d", c));
            @(negedge clk); data_data_ok = 0; #1;
        end
        $display("seq reset_in_wait done");

        // Reset while requesting: data_req drops in the same cycle
        @(negedge clk); op_valid = 1; op = EXE_SW_OP; addr = 32'h6000; wdata = 32'h1111_2222;
        @(negedge clk); #1;
        chk("rst_req pre data_req", 32'(data_req), 32'd1);
        rst = 1; #1;
        chk("rst_req data_req", 32'(data_req), 32'd0);
        @(negedge clk); rst = 0; op_valid = 0; #2;
        chk_idle_outputs("rst_req after");
        $display("seq reset_in_req done");

        // Randomized transactions against the reference model
        ops = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
                EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, 8'h25, 8'h00};
        last_rdata = 32'h0;
        for (int t = 0; t < 150; t++) begin
            logic [7:0]  o;
            logic [31:0] a;
            logic [31:0] w;
            logic [31:0] rd;
            int aok;
            int dok;
            bit spur;
            o    = ops[$urandom_range(0, 9)];
            a    = $urandom();
            w    = $urandom();
            rd   = $urandom();
            aok  = $urandom_range(0, 3);
            dok  = $urandom_range(0, 3);
            spur = 1'($urandom_range(0, 1));
            e = ref_model(o, a, w, rd, aok, dok, last_rdata);
            run_txn(o, a, w, rd, aok, dok, spur, r);
            if (!e.wr) e.wdata = r.wdata;
            $display("rand %0d op=%h addr=%h aok=%0d dok=%0d spur=%0d stall=%0d rdata=%h",
                     t, o, a, aok, dok, spur, r.stall, r.rdata);
            compare($sformatf("rand%0d", t), r, e);
            last_rdata = e.rdata;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
